// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSID result path.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;

    typedef enum logic [1:0] {
        HSID_BM_IDLE,
        HSID_BM_RUN,
        HSID_BM_DONE
    } hsid_bm_state_t;

    localparam logic [HSID_WORD_WIDTH-1:0] HSID_BM_MIN_INIT = '1;

endpackage

// File: rtl/hsid_extreme_tracker.sv
// Holds the running minimum (IS_MIN=1) or maximum (IS_MIN=0) value and its library ref.
module hsid_extreme_tracker
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter bit IS_MIN            = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         init,
    input  logic                         load,
    input  logic                         upd,
    input  logic [WORD_WIDTH-1:0]        value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] lib_ref,
    output logic [WORD_WIDTH-1:0]        ext_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] ext_ref
);

    // Min starts at all-ones and max at zero so that any real value displaces them.
    localparam logic [WORD_WIDTH-1:0] INIT_VALUE = {WORD_WIDTH{IS_MIN}};

    logic better;

    // Strict compare: a tie keeps the earlier-arriving ref.
    always_comb begin
        better = 1'b0;
        if (IS_MIN) begin
            better = value < ext_value;
        end else begin
            better = value > ext_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_value <= '0;
            ext_ref   <= '0;
        end else if (clear) begin
            ext_value <= '0;
            ext_ref   <= '0;
        end else if (init) begin
            ext_value <= INIT_VALUE;
            ext_ref   <= '0;
        end else if (load || (upd && better)) begin
            ext_value <= value;
            ext_ref   <= lib_ref;
        end
    end

endmodule

// File: rtl/hsid_best_match.sv
// Best/worst match selection over one library scan of MSE results.
module hsid_best_match
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic                         in_valid,
    input  logic [WORD_WIDTH-1:0]        in_value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] in_ref,
    input  logic                         in_of,
    output logic                         busy,
    output logic                         result_valid,
    output logic [WORD_WIDTH-1:0]        min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
    output logic [WORD_WIDTH-1:0]        max_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
    output logic [HSP_LIBRARY_WIDTH-1:0] of_count,
    output logic                         no_match
);

    localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE = {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};

    hsid_bm_state_t                 state;
    logic [HSP_LIBRARY_WIDTH-1:0]   size_q;
    logic [HSP_LIBRARY_WIDTH-1:0]   cnt;
    logic [HSP_LIBRARY_WIDTH-1:0]   cnt_inc;
    logic [HSP_LIBRARY_WIDTH-1:0]   of_cnt;
    logic                           seen_ok;
    logic                           no_match_q;
    logic                           start_go;
    logic                           accept;
    logic                           ok_hit;
    logic [WORD_WIDTH-1:0]          min_raw;
    logic [WORD_WIDTH-1:0]          max_raw;

    assign start_go = start && (state != HSID_BM_RUN);
    assign accept   = in_valid && (state == HSID_BM_RUN);
    assign ok_hit   = accept && !in_of;
    // cnt stays below size_q in RUN, so the increment cannot wrap.
    assign cnt_inc  = cnt + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HSID_BM_IDLE;
            size_q       <= '0;
            cnt          <= '0;
            of_cnt       <= '0;
            seen_ok      <= 1'b0;
            no_match_q   <= 1'b0;
            result_valid <= 1'b0;
        end else if (clear) begin
            state        <= HSID_BM_IDLE;
            size_q       <= '0;
            cnt          <= '0;
            of_cnt       <= '0;
            seen_ok      <= 1'b0;
            no_match_q   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start_go) begin
                size_q  <= library_size;
                cnt     <= '0;
                of_cnt  <= '0;
                seen_ok <= 1'b0;
                if (library_size == '0) begin
                    state        <= HSID_BM_DONE;
                    result_valid <= 1'b1;
                    no_match_q   <= 1'b1;
                end else begin
                    state      <= HSID_BM_RUN;
                    no_match_q <= 1'b0;
                end
            end else if (accept) begin
                cnt <= cnt_inc;
                if (in_of) begin
                    of_cnt <= of_cnt + ONE;
                end else begin
                    seen_ok <= 1'b1;
                end
                if (cnt_inc == size_q) begin
                    state        <= HSID_BM_DONE;
                    result_valid <= 1'b1;
                    no_match_q   <= !(seen_ok || !in_of);
                end
            end
        end
    end

    hsid_extreme_tracker #(
        .WORD_WIDTH        (WORD_WIDTH),
        .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH),
        .IS_MIN            (1'b1)
    ) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .init      (start_go),
        .load      (ok_hit && !seen_ok),
        .upd       (ok_hit && seen_ok),
        .value     (in_value),
        .lib_ref   (in_ref),
        .ext_value (min_raw),
        .ext_ref   (min_ref)
    );

    hsid_extreme_tracker #(
        .WORD_WIDTH        (WORD_WIDTH),
        .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH),
        .IS_MIN            (1'b0)
    ) u_max (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .init      (start_go),
        .load      (ok_hit && !seen_ok),
        .upd       (ok_hit && seen_ok),
        .value     (in_value),
        .lib_ref   (in_ref),
        .ext_value (max_raw),
        .ext_ref   (max_ref)
    );

    // A scan with no usable result reports zero rather than the all-ones min seed.
    assign min_value = no_match_q ? '0 : min_raw;
    assign max_value = no_match_q ? '0 : max_raw;
    assign of_count  = of_cnt;
    assign no_match  = no_match_q;
    assign busy      = (state == HSID_BM_RUN);

endmodule

// File: tb/tb_hsid_best_match.sv
// Directed bench for hsid_best_match with a scan-level reference model.
module tb_hsid_best_match;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  library_size = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_value = '0;
    logic [7:0]  in_ref = '0;
    logic        in_of = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] min_value;
    logic [7:0]  min_ref;
    logic [31:0] max_value;
    logic [7:0]  max_ref;
    logic [7:0]  of_count;
    logic        no_match;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hsid_best_match dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .start        (start),
        .library_size (library_size),
        .in_valid     (in_valid),
        .in_value     (in_value),
        .in_ref       (in_ref),
        .in_of        (in_of),
        .busy         (busy),
        .result_valid (result_valid),
        .min_value    (min_value),
        .min_ref      (min_ref),
        .max_value    (max_value),
        .max_ref      (max_ref),
        .of_count     (of_count),
        .no_match     (no_match)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: records each accepted result of a scan, then derives the summary.
    typedef struct {
        logic [31:0] v;
        logic [7:0]  r;
        logic        o;
    } res_t;

    res_t        q[$];
    bit          m_running = 0;
    bit          m_pulse = 0;
    bit          m_zero = 1;
    int          m_size = 0;
    logic [31:0] e_min, e_max;
    logic [7:0]  e_minr, e_maxr, e_of;
    logic        e_nm;

    task automatic summarise();
        int n_ok;
        n_ok = 0; e_of = 0;
        e_min = 0; e_max = 0; e_minr = 0; e_maxr = 0;
        foreach (q[i]) begin
            if (q[i].o) e_of++;
            else begin
                if (n_ok == 0 || q[i].v < e_min) e_min = q[i].v;
                if (n_ok == 0 || q[i].v > e_max) e_max = q[i].v;
                n_ok++;
            end
        end
        e_nm = (n_ok == 0);
        // Ref of an extreme is the first arrival carrying that value.
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!q[i].o && q[i].v == e_min) e_minr = q[i].r;
            if (!q[i].o && q[i].v == e_max) e_maxr = q[i].r;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".min_value"}, min_value, 0);
        chk({tag, ".min_ref"}, min_ref, 0);
        chk({tag, ".max_value"}, max_value, 0);
        chk({tag, ".max_ref"}, max_ref, 0);
        chk({tag, ".of_count"}, of_count, 0);
        chk({tag, ".no_match"}, no_match, 0);
    endtask

    // Compare process: check outputs against the model, then fold in this cycle's inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete(); m_running = 0; m_pulse = 0; m_zero = 1;
                chk("reset.busy", busy, 0);
                chk("reset.result_valid", result_valid, 0);
                chk_zero("reset");
            end else begin
                chk("busy", busy, m_running);
                chk("result_valid", result_valid, m_pulse);
                if (m_pulse) begin
                    chk("min_value", min_value, e_min);
                    chk("min_ref", min_ref, e_minr);
                    chk("max_value", max_value, e_max);
                    chk("max_ref", max_ref, e_maxr);
                    chk("of_count", of_count, e_of);
                    chk("no_match", no_match, e_nm);
                end
                if (m_zero) chk_zero("idle");
                m_pulse = 0;
                if (clear) begin
                    q.delete(); m_running = 0; m_zero = 1;
                end else if (start && !m_running) begin
                    q.delete(); m_zero = 0;
                    if (library_size == 0) begin
                        summarise();
                        m_pulse = 1;
                    end else begin
                        m_running = 1;
                        m_size = library_size;
                    end
                end else if (m_running && in_valid) begin
                    q.push_back('{in_value, in_ref, in_of});
                    if (q.size() == m_size) begin
                        summarise();
                        m_pulse = 1;
                        m_running = 0;
                    end
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        start = 0; clear = 0; in_valid = 0; in_of = 0;
    endtask

    task automatic drive_start(input logic [7:0] size);
        @(posedge clk); #1;
        start = 1; library_size = size; clear = 0; in_valid = 0;
    endtask

    task automatic strobe(input logic [31:0] v, input logic [7:0] r, input logic o);
        @(posedge clk); #1;
        start = 0; clear = 0; in_valid = 1; in_value = v; in_ref = r; in_of = o;
    endtask

    task automatic wait_result(input string name, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid) begin
                found = 1;
                break;
            end
        end
        chk({name, ".pulse_seen"}, found, 1);
    endtask

    task automatic expect_res(input string name, input logic [31:0] mn, input logic [7:0] mnr,
                              input logic [31:0] mx, input logic [7:0] mxr,
                              input logic [7:0] ofc, input logic nm);
        chk({name, ".min_value"}, min_value, mn);
        chk({name, ".min_ref"}, min_ref, mnr);
        chk({name, ".max_value"}, max_value, mx);
        chk({name, ".max_ref"}, max_ref, mxr);
        chk({name, ".of_count"}, of_count, ofc);
        chk({name, ".no_match"}, no_match, nm);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Strobes while IDLE are dropped.
        strobe(32'd5, 8'd3, 1'b0);
        strobe(32'd6, 8'd4, 1'b0);
        idle();
        idle();

        // 1: plain scan with a tie on the minimum.
        drive_start(8'd4);
        strobe(32'd50, 8'd0, 1'b0);
        strobe(32'd20, 8'd1, 1'b0);
        strobe(32'd90, 8'd2, 1'b0);
        strobe(32'd20, 8'd3, 1'b0);
        idle();
        wait_result("t1", 4);
        expect_res("t1", 32'd20, 8'd1, 32'd90, 8'd2, 8'd0, 1'b0);

        // 2: overflowed results are counted but not compared.
        drive_start(8'd3);
        strobe(32'd1, 8'd0, 1'b1);
        strobe(32'd7, 8'd1, 1'b0);
        strobe(32'd2, 8'd2, 1'b1);
        idle();
        wait_result("t2", 4);
        expect_res("t2", 32'd7, 8'd1, 32'd7, 8'd1, 8'd2, 1'b0);

        // 3: every result overflowed.
        drive_start(8'd2);
        strobe(32'd3, 8'd0, 1'b1);
        strobe(32'd4, 8'd1, 1'b1);
        idle();
        wait_result("t3", 4);
        expect_res("t3", 32'd0, 8'd0, 32'd0, 8'd0, 8'd2, 1'b1);

        // 4: empty library.
        drive_start(8'd0);
        idle();
        wait_result("t4", 2);
        expect_res("t4", 32'd0, 8'd0, 32'd0, 8'd0, 8'd0, 1'b1);
        chk("t4.busy", busy, 0);

        // 5: clear mid-scan with competing start/strobe, then a fresh scan.
        drive_start(8'd5);
        strobe(32'd11, 8'd0, 1'b0);
        strobe(32'd12, 8'd1, 1'b0);
        @(posedge clk); #1;
        clear = 1; start = 1; library_size = 8'd1; in_valid = 1; in_value = 32'd0; in_of = 0;
        idle();
        repeat (4) idle();
        drive_start(8'd2);
        strobe(32'd3, 8'd8, 1'b0);
        strobe(32'd1, 8'd9, 1'b0);
        idle();
        wait_result("t5", 4);
        expect_res("t5", 32'd1, 8'd9, 32'd3, 8'd8, 8'd0, 1'b0);

        // 6: strobes in DONE dropped, start during RUN ignored, 8 back-to-back results.
        strobe(32'd0, 8'd7, 1'b0);
        strobe(32'd100, 8'd7, 1'b0);
        drive_start(8'd8);
        strobe(32'd40, 8'd0, 1'b0);
        strobe(32'd10, 8'd1, 1'b0);
        strobe(32'd40, 8'd2, 1'b0);
        @(posedge clk); #1;
        start = 1; library_size = 8'd2; in_valid = 1; in_value = 32'd10; in_ref = 8'd3; in_of = 0;
        strobe(32'd99, 8'd4, 1'b0);
        strobe(32'd5, 8'd5, 1'b0);
        strobe(32'd99, 8'd6, 1'b0);
        strobe(32'd1, 8'd7, 1'b1);
        idle();
        wait_result("t6", 4);
        expect_res("t6", 32'd5, 8'd5, 32'd99, 8'd4, 8'd1, 1'b0);
        idle();
        strobe(32'd2, 8'd9, 1'b0);
        idle();
        chk("t6.hold_min", min_value, 32'd5);
        chk("t6.hold_max_ref", max_ref, 8'd4);

        // clear from DONE zeroes everything.
        @(posedge clk); #1 clear = 1;
        idle();
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
